// File: rtl/instr_fetch.sv
// instr_fetch: requesting end of the instruction-memory read port.
// Holds the PC, drives the fetch address, captures the returned word and
// hands it to decode over a valid/ready handshake. A halt word accepted by
// decode stops the unit until reset; execute can redirect the PC at any time
// while fetching or holding.
module instr_fetch #(
  parameter int                ADDR_W      = 12,
  parameter int                INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Opcode field sits in the top four bits of the instruction word.
  localparam int OP_LSB = INSTR_W - 4;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc, pc_n;
  logic [INSTR_W-1:0] instr_n;
  logic [ADDR_W-1:0]  instr_pc_n;
  logic               instr_valid_n;
  logic               halted_n;
  logic               accept;

  // Decode takes the held word when both sides agree in the same cycle.
  assign accept = instr_valid & instr_ready;

  // Address comes straight from the PC register, so it never glitches.
  assign instr_addr = pc;

  // Busy is a pure decode of the registered state.
  assign busy = (state == S_FETCH) || (state == S_HOLD);

  // State and datapath registers; synchronous reset to the idle condition.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      halted      <= halted_n;
    end
  end

  // Next-state and next-datapath logic; redirect outranks everything else
  // while the unit is active.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    halted_n      = halted;

    unique case (state)
      S_IDLE: begin
        if (redirect) begin
          pc_n = redirect_addr;
        end
        if (run) begin
          state_n = S_FETCH;
        end
      end

      S_FETCH: begin
        if (redirect) begin
          // The word on instr_in belongs to the old path: drop it.
          pc_n          = redirect_addr;
          instr_valid_n = 1'b0;
          state_n       = S_FETCH;
        end else begin
          instr_n       = instr_in;
          instr_pc_n    = pc;
          instr_valid_n = 1'b1;
          pc_n          = pc + ADDR_W'(1);
          state_n       = S_HOLD;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          // A coincident accept still counts at decode, but the halt check
          // is skipped because execution continues at the target.
          pc_n          = redirect_addr;
          instr_valid_n = 1'b0;
          state_n       = S_FETCH;
        end else if (accept) begin
          instr_valid_n = 1'b0;
          if (instr[INSTR_W-1:OP_LSB] == HALT_OPCODE) begin
            halted_n = 1'b1;
            state_n  = S_HALT;
          end else begin
            state_n = S_FETCH;
          end
        end
      end

      S_HALT: begin
        // Frozen until reset; run and redirect are ignored.
        instr_valid_n = 1'b0;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the requesting end of the instruction-memory read port. Holds the program counter, drives the 12-bit instruction address, captures the 16-bit word returned combinationally by the instruction memory, and presents it to decode with a valid/ready handshake. Stops permanently on a halt word until reset; accepts branch/jump redirects from execute.

## Interface
- ADDR_W, 12, instruction address width (4096-word space)
- INSTR_W, 16, instruction width
- RESET_PC, 12'h000, PC value loaded on reset
- HALT_OPCODE, 4'b0000, value of instr[15:12] that marks halt
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- run  in  1  start fetching from IDLE
- instr_addr  out  ADDR_W  address to instruction memory; equals current PC
- instr_in  in  INSTR_W  word from instruction memory, valid same cycle as instr_addr
- instr  out  INSTR_W  held instruction to decode
- instr_pc  out  ADDR_W  address the held instruction was fetched from
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decode accepts when high with instr_valid
- redirect  in  1  load PC from redirect_addr, squash held instruction
- redirect_addr  in  ADDR_W  redirect target
- busy  out  1  high in FETCH or HOLD
- halted  out  1  halt word accepted by decode; sticky until reset

## Operation
- States: IDLE, FETCH, HOLD, HALT. Reset -> IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, busy=0. instr_addr=pc at all times (registered, glitch-free).
- IDLE: run=1 -> FETCH. redirect=1 -> pc<=redirect_addr, stay IDLE (redirect beats run if both high: load pc, go FETCH).
- FETCH (one cycle): at clock edge instr<=instr_in, instr_pc<=pc, instr_valid<=1, pc<=pc+1 modulo 2^ADDR_W (12'hFFF wraps to 12'h000), -> HOLD.
- HOLD: instr_valid=1, instr/instr_pc stable until accepted. Accept = instr_valid & instr_ready. On accept: instr_valid<=0; if instr[15:12]==HALT_OPCODE -> HALT, halted<=1; else -> FETCH. No accept: stay.
- Redirect priority: in FETCH or HOLD, redirect=1 -> pc<=redirect_addr, instr_valid<=0, -> FETCH; the word being fetched in FETCH is discarded. Redirect with simultaneous accept in HOLD: accept is counted by decode, halt check skipped, next fetch at redirect_addr.
- HALT: instr_valid=0, busy=0, halted=1, pc frozen; run and redirect ignored. Exit only via reset.
- Reset mid-operation: any state -> IDLE with reset values on the next edge; an un-accepted instruction is dropped.
- instr_valid never drops without accept or redirect; instr never changes while instr_valid=1.

## Timing
- run sampled high at edge E0 -> FETCH during cycle after E0, instr_addr=pc -> instr_valid=1 after edge E1.
- Accept at edge En -> FETCH cycle, instr_valid=1 after En+1 (instr_valid low for exactly one cycle). Peak throughput 1 instruction / 2 cycles.
- Redirect sampled at edge Er -> instr_addr=redirect_addr after Er, instr_valid=1 with target word after Er+1.
- halted rises on the same edge the halt word is accepted.
- instr_in is sampled only at the end of FETCH; memory read path is combinational and must settle within one cycle.

## Test plan
- Memory image 0x2001,0x2002,0x2003,0x0000; reset, run pulse, instr_ready=1 -> instr/instr_pc sequence 0x2001/0, 0x2002/1, 0x2003/2, 0x0000/3 spaced 2 cycles, then halted=1, busy=0, instr_addr stays 4.
- Same image, instr_ready=0 for 5 cycles on second word -> instr=0x2002, instr_pc=1 held stable all 5 cycles; no address advance beyond 2.
- Redirect to 12'h002 while HOLD with 0x2001 and instr_ready=0 -> next valid word 0x2003, instr_pc=2; 0x2001 never accepted.
- RESET_PC=12'hFFF, mem[FFF]=0x2005, mem[0]=0x0000 -> words 0x2005/FFF then 0x0000/000, halted=1 (wrap).
- Assert reset in HOLD with instr_valid=1 -> next cycle instr_valid=0, instr=0, instr_pc=0, state IDLE, instr_addr=RESET_PC; run/redirect in HALT produce no change.
